// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide sequencer: operand width, op codes,
// ALU op codes that share this header, FSM encoding and operand helpers.
package muldiv_unit_pkg;

   localparam int XLEN = 32;
   localparam int CNTW = 5;

   localparam logic [1:0] MD_OP_MULT  = 2'd0;
   localparam logic [1:0] MD_OP_MULTU = 2'd1;
   localparam logic [1:0] MD_OP_DIV   = 2'd2;
   localparam logic [1:0] MD_OP_DIVU  = 2'd3;

   localparam logic [3:0] ALU_OP_ADD  = 4'd0;
   localparam logic [3:0] ALU_OP_SUB  = 4'd1;
   localparam logic [3:0] ALU_OP_AND  = 4'd2;
   localparam logic [3:0] ALU_OP_OR   = 4'd3;
   localparam logic [3:0] ALU_OP_XOR  = 4'd4;
   localparam logic [3:0] ALU_OP_NOR  = 4'd5;
   localparam logic [3:0] ALU_OP_SLT  = 4'd6;
   localparam logic [3:0] ALU_OP_SLTU = 4'd7;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

   // op[0] clear means the signed flavour (MULT / DIV).
   function automatic logic md_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic [XLEN-1:0] md_mag(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO owner: 32-step shift-add multiplier and restoring divider
// sharing one 64-bit accumulator, plus MTHI/MTLO writes while idle.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            mthi,
   input  logic            mtlo,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done,
   output logic            dz,
   output md_state_e       dbg_state
);

   md_state_e           state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [XLEN-1:0]     opa_q, opa_d;     // multiplicand, or dividend shifting out MSB-first
   logic [XLEN-1:0]     opb_q, opb_d;     // multiplier shifting out LSB-first, or divisor
   logic [XLEN-1:0]     araw_q, araw_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic                dz_flag_q, dz_flag_d;
   logic [XLEN-1:0]     hi_q, hi_d;
   logic [XLEN-1:0]     lo_q, lo_d;
   logic                done_q, done_d;
   logic                dz_q, dz_d;

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_acc;
   logic [XLEN:0]       rem_sh;
   logic                div_ok;
   logic [XLEN-1:0]     div_rem;
   logic [2*XLEN-1:0]   div_acc;
   logic [2*XLEN-1:0]   prod_fix;

   // Multiply step: conditional add into the upper half, then shift {carry, acc} right.
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
   assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

   // Divide step: remainder pulls in the next dividend bit, quotient bit shifts into the low half.
   assign rem_sh  = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
   assign div_ok  = (rem_sh >= {1'b0, opb_q});
   assign div_rem = rem_sh[XLEN-1:0] - opb_q;
   assign div_acc = {(div_ok ? div_rem : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};

   assign prod_fix = neg_quo_q ? (~acc_q + 1'b1) : acc_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      araw_d    = araw_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_flag_d = dz_flag_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dz_d      = 1'b0;

      case (state_q)
         MD_IDLE: begin
            if (start) begin
               op_d      = op;
               opa_d     = md_mag(a, md_is_signed(op));
               opb_d     = md_mag(b, md_is_signed(op));
               araw_d    = a;
               neg_quo_d = md_is_signed(op) & (a[XLEN-1] ^ b[XLEN-1]);
               neg_rem_d = md_is_signed(op) & a[XLEN-1];
               dz_flag_d = (b == '0) & op[1];
               cnt_d     = '0;
               acc_d     = '0;
               state_d   = MD_CALC;
            end else begin
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
            end
         end

         MD_CALC: begin
            if (op_q[1]) begin
               acc_d = div_acc;
               opa_d = {opa_q[XLEN-2:0], 1'b0};
            end else begin
               acc_d = mul_acc;
               opb_d = {1'b0, opb_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {CNTW{1'b1}}) state_d = MD_FIX;
         end

         MD_FIX: begin
            done_d  = 1'b1;
            dz_d    = dz_flag_q;
            state_d = MD_IDLE;
            if (!op_q[1]) begin
               hi_d = prod_fix[2*XLEN-1:XLEN];
               lo_d = prod_fix[XLEN-1:0];
            end else if (dz_flag_q) begin
               hi_d = araw_q;
               lo_d = '1;
            end else begin
               lo_d = neg_quo_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
               hi_d = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
            end
         end

         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MD_IDLE;
         op_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         araw_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_flag_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         araw_q    <= araw_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_flag_q <= dz_flag_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
      end
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign busy      = (state_q != MD_IDLE);
   assign done      = done_q;
   assign dz        = dz_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit: results are predicted with plain
// 64-bit arithmetic and compared by an independent monitor whenever done pulses.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [1:0]      op;
   logic [31:0]     a;
   logic [31:0]     b;
   logic            mthi;
   logic            mtlo;
   logic [31:0]     wdata;
   logic [31:0]     hi;
   logic [31:0]     lo;
   logic            busy;
   logic            done;
   logic            dz;
   md_state_e       dbg_state;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [64:0] exp_q[$];   // {dz, hi, lo}
   int          lat_q[$];   // cycle count just after the accepting edge
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] ref_hi = '0;
   logic [31:0] ref_lo = '0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: signed ops via 64-bit integer arithmetic (truncating division).
   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, sp, sq, sr;
      logic [63:0] up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         MD_OP_MULT:  begin sp = sx * sy; return {1'b0, sp[63:0]}; end
         MD_OP_MULTU: begin up = {32'd0, x} * {32'd0, y}; return {1'b0, up}; end
         default: begin
            if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
            if (o == MD_OP_DIV) begin
               sq = sx / sy;
               sr = sx % sy;
               return {1'b0, sr[31:0], sq[31:0]};
            end
            return {1'b0, x % y, x / y};
         end
      endcase
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [64:0] e;
      int          l;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", {64'd0, done}, 65'd0);
         end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            check("result", {dz, hi, lo}, e);
            check("latency", 65'(cyc - l), 65'd33);
            check("busy_at_done", {64'd0, busy}, 65'd0);
         end
      end
      if (dz === 1'b1 && done !== 1'b1) check("dz_without_done", {64'd0, dz}, 65'd0);
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (busy !== 1'b0) check("idle_timeout", {64'd0, busy}, 65'd0);
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 65'(exp_q.size()), 65'd0);
         exp_q.delete();
         lat_q.delete();
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [64:0] e;
      wait_idle();
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      e = model(o, x, y);
      exp_q.push_back(e);
      lat_q.push_back(cyc);
      ref_hi = e[63:32];
      ref_lo = e[31:0];
   endtask

   task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
      @(negedge clk);
      mthi = h; mtlo = l; wdata = d;
      @(posedge clk);
      #1 mthi = 1'b0; mtlo = 1'b0;
      if (h) ref_hi = d;
      if (l) ref_lo = d;
      check("mt_hi", {33'd0, hi}, {33'd0, ref_hi});
      check("mt_lo", {33'd0, lo}, {33'd0, ref_lo});
      check("mt_busy", {64'd0, busy}, 65'd0);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 9))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int          busy_cnt;
      int          k;
      logic [64:0] e;
      logic [31:0] old_hi;

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hi",    {33'd0, hi}, 65'd0);
      check("rst_lo",    {33'd0, lo}, 65'd0);
      check("rst_busy",  {64'd0, busy}, 65'd0);
      check("rst_done",  {64'd0, done}, 65'd0);
      check("rst_dz",    {64'd0, dz}, 65'd0);
      check("rst_state", {63'd0, dbg_state}, {63'd0, MD_IDLE});
      rst = 1'b0;

      // MULTU max * max, with busy span E0..E33 counted on falling edges
      issue(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      busy_cnt = 0; k = 0;
      @(negedge clk);
      while (done !== 1'b1 && k < 60) begin
         busy_cnt += int'(busy);
         @(negedge clk);
         k++;
      end
      check("busy_cycles", 65'(busy_cnt), 65'd33);
      wait_drain();
      check("multu_hi", {33'd0, hi}, {33'd0, 32'hFFFF_FFFE});
      check("multu_lo", {33'd0, lo}, {33'd0, 32'h0000_0001});

      issue(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7); wait_drain();
      check("mult_hi", {33'd0, hi}, {33'd0, 32'hFFFF_FFFF});
      check("mult_lo", {33'd0, lo}, {33'd0, 32'hFFFF_FFEB});

      issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2); wait_drain();
      check("div_neg_lo", {33'd0, lo}, {33'd0, 32'hFFFF_FFFD});
      check("div_neg_hi", {33'd0, hi}, {33'd0, 32'hFFFF_FFFF});

      issue(MD_OP_DIVU, 32'd7, 32'd2); wait_drain();
      check("divu_lo", {33'd0, lo}, 65'd3);
      check("divu_hi", {33'd0, hi}, 65'd1);

      issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_drain();
      check("div_ovf_lo", {33'd0, lo}, {33'd0, 32'h8000_0000});
      check("div_ovf_hi", {33'd0, hi}, 65'd0);

      issue(MD_OP_DIV, 32'd5, 32'd0); wait_drain();
      check("dz_hi", {33'd0, hi}, 65'd5);
      check("dz_lo", {33'd0, lo}, {33'd0, 32'hFFFF_FFFF});
      @(negedge clk);
      check("dz_one_cycle", {64'd0, dz}, 65'd0);

      // requests during CALC are ignored
      issue(MD_OP_MULTU, 32'd100, 32'd3);
      repeat (5) @(negedge clk);
      mthi = 1'b1; wdata = 32'h1234; start = 1'b1; op = MD_OP_DIVU; a = 32'd9; b = 32'd4;
      @(negedge clk);
      mthi = 1'b0; start = 1'b0;
      wait_drain();
      check("busy_mthi_hi", {33'd0, hi}, 65'd0);
      check("busy_lo", {33'd0, lo}, 65'd300);
      mt_write(1'b0, 1'b1, 32'h0000_ABCD);
      check("mtlo_done", {64'd0, done}, 65'd0);

      // start and mthi together in IDLE: the write is dropped
      wait_idle();
      old_hi = ref_hi;
      @(negedge clk);
      op = MD_OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1; mthi = 1'b1; wdata = 32'h5555;
      @(posedge clk);
      #1 start = 1'b0; mthi = 1'b0;
      check("start_wins_hi", {33'd0, hi}, {33'd0, old_hi});
      e = model(MD_OP_MULTU, 32'd2, 32'd3);
      exp_q.push_back(e); lat_q.push_back(cyc);
      ref_hi = e[63:32]; ref_lo = e[31:0];
      wait_drain();
      mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);

      // reset mid-operation aborts without done
      issue(MD_OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete(); lat_q.delete();
      ref_hi = '0; ref_lo = '0;
      check("rstmid_hi", {33'd0, hi}, 65'd0);
      check("rstmid_lo", {33'd0, lo}, 65'd0);
      check("rstmid_busy", {64'd0, busy}, 65'd0);
      repeat (40) @(negedge clk);
      issue(MD_OP_MULTU, 32'd6, 32'd7); wait_drain();
      check("post_rst_lo", {33'd0, lo}, 65'd42);

      // start held high: one accept every 34 cycles
      wait_idle();
      @(negedge clk);
      op = MD_OP_MULT; a = 32'hFFFF_F000; b = 32'd12345; start = 1'b1;
      @(posedge clk);
      #1;
      e = model(MD_OP_MULT, 32'hFFFF_F000, 32'd12345);
      exp_q.push_back(e); lat_q.push_back(cyc);
      exp_q.push_back(e); lat_q.push_back(cyc + 34);
      ref_hi = e[63:32]; ref_lo = e[31:0];
      repeat (34) @(posedge clk);
      #1 start = 1'b0;
      wait_drain();

      // randomised ops with interleaved MTHI/MTLO
      for (int i = 0; i < 30; i++) begin
         issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand());
         wait_drain();
         if ($urandom_range(0, 3) == 0)
            mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
